// File: rtl/vga_fbuf_pkg.sv
// Purpose: shared derived constants, width helper and FSM state types for the frame-buffer reader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vga_fbuf_pkg;

   // Default display geometry and the frame-buffer shape derived from it.
   localparam int DISP_WIDTH_DEF      = 640;
   localparam int DISP_HEIGHT_DEF     = 480;
   localparam int SCALE_DEF           = 4;
   localparam int PIXEL_WIDTH_DEF     = 12;
   localparam int PIXELS_PER_WORD_DEF = 2;

   localparam int FB_WIDTH   = DISP_WIDTH_DEF / SCALE_DEF;
   localparam int FB_HEIGHT  = DISP_HEIGHT_DEF / SCALE_DEF;
   localparam int WPL        = FB_WIDTH / PIXELS_PER_WORD_DEF;
   localparam int FB_WORDS   = WPL * FB_HEIGHT;
   localparam int ADDR_W     = $clog2(FB_WORDS);
   localparam int WORD_WIDTH = PIXEL_WIDTH_DEF * PIXELS_PER_WORD_DEF;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {RD_IDLE = 1'b0, RD_RUN = 1'b1} rd_state_t;
   typedef enum logic {OUT_IDLE = 1'b0, OUT_RUN = 1'b1} out_state_t;

endpackage

// File: rtl/vga_fbuf_prefetch_fifo.sv
// Purpose: small synchronous first-word-fall-through FIFO holding prefetched frame-buffer words.
// Latency: a word pushed in cycle N is visible at head_dat in cycle N+1.
// Backpressure: push while full and pop while empty are ignored; flush wins over push/pop.
module vga_fbuf_prefetch_fifo
   import vga_fbuf_pkg::*;
#(
   parameter  int WIDTH = 24,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = cw(DEPTH)
)(
   input  logic             clka,
   input  logic             rsta,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count == '0);
   assign do_push  = push && (count != CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   // Storage array: plain write port, no reset needed.
   always_ff @(posedge clka) begin
      if (do_push && !flush) mem[wr_ptr] <= push_dat;
   end

   // Pointers and occupancy; flush empties the FIFO in one cycle.
   always_ff @(posedge clka) begin
      if (rsta || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/vga_fbuf_reader.sv
// Purpose: raster-order frame-buffer reader with prefetch, pixel unpack and SCALE x SCALE replication.
// Latency: frame_start_i in cycle 0 -> first BRAM read cycle 1 -> first pixel valid cycle 3.
// Backpressure: pix_ready_i low holds the pixel; reads stop once FIFO plus in-flight reach PREFETCH_DEPTH.
// Optional: define VGA_FBUF_UNDERRUN_EN to add the sticky underrun_o flag.
module vga_fbuf_reader
   import vga_fbuf_pkg::*;
#(
   parameter  int DISP_WIDTH      = 640,
   parameter  int DISP_HEIGHT     = 480,
   parameter  int SCALE           = 4,
   parameter  int PIXEL_WIDTH     = 12,
   parameter  int PIXELS_PER_WORD = 2,
   parameter  int PREFETCH_DEPTH  = 4,
   localparam int SRC_W           = DISP_WIDTH / SCALE,
   localparam int SRC_H           = DISP_HEIGHT / SCALE,
   localparam int LINE_WORDS      = SRC_W / PIXELS_PER_WORD,
   localparam int FRAME_WORDS     = LINE_WORDS * SRC_H,
   localparam int AW              = cw(FRAME_WORDS),
   localparam int WW              = PIXEL_WIDTH * PIXELS_PER_WORD
)(
   input  logic                   clka,
   input  logic                   rsta,
   input  logic                   frame_start_i,
   output logic [AW-1:0]          addra_o,
   output logic                   ena_o,
   output logic                   wea_o,
   input  logic [WW-1:0]          douta_i,
   output logic [PIXEL_WIDTH-1:0] pix_data_o,
   output logic                   pix_valid_o,
   input  logic                   pix_ready_i,
   output logic                   frame_done_o
`ifdef VGA_FBUF_UNDERRUN_EN
   ,
   output logic                   underrun_o
`endif
);

   localparam int WD_W  = cw(LINE_WORDS);
   localparam int RP_W  = cw(SCALE);
   localparam int LN_W  = cw(SRC_H);
   localparam int SUB_W = cw(PIXELS_PER_WORD);
   localparam int X_W   = cw(DISP_WIDTH);
   localparam int Y_W   = cw(DISP_HEIGHT);
   localparam int CNT_W = $clog2(PREFETCH_DEPTH + 1);
   localparam int OCC_W = CNT_W + 2;

   // One pixel per cycle needs each word to last at least two transfers.
   if (SCALE * PIXELS_PER_WORD < 2) begin : g_chk_tput
      $error("vga_fbuf_reader: SCALE*PIXELS_PER_WORD must be at least 2");
   end
   if (PREFETCH_DEPTH < 2) begin : g_chk_depth
      $error("vga_fbuf_reader: PREFETCH_DEPTH must be at least 2");
   end

   // Read side state.
   rd_state_t         rd_state, rd_state_nxt;
   logic [WD_W-1:0]   rd_word, rd_word_nxt, b_word;
   logic [RP_W-1:0]   rd_rep, rd_rep_nxt, b_rep;
   logic [LN_W-1:0]   rd_line, rd_line_nxt, b_line;
   logic              rd_pend;
   logic              ena_nxt;
   logic [AW-1:0]     addra_nxt;
   logic              b_run;
   logic [OCC_W-1:0]  occ;

   // Output side state.
   out_state_t        out_state, out_state_nxt;
   logic [SUB_W-1:0]  sub, sub_nxt;
   logic [RP_W-1:0]   hrep, hrep_nxt;
   logic [X_W-1:0]    out_x, out_x_nxt;
   logic [Y_W-1:0]    out_y, out_y_nxt;
   logic              done_nxt;
   logic              xfer;

   // FIFO interface.
   logic              fifo_push, fifo_pop, fifo_empty;
   logic [WW-1:0]     fifo_head;
   logic [CNT_W-1:0]  fifo_count;

   assign wea_o       = 1'b0;
   assign pix_valid_o = (out_state == OUT_RUN) && !fifo_empty;
   assign xfer        = pix_valid_o && pix_ready_i;
   assign fifo_push   = rd_pend && !frame_start_i;
   assign fifo_pop    = xfer && (hrep == RP_W'(SCALE - 1))
                        && (sub == SUB_W'(PIXELS_PER_WORD - 1)) && !frame_start_i;
   assign pix_data_o  = pix_valid_o ? fifo_head[int'(sub)*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;

   vga_fbuf_prefetch_fifo #(
      .WIDTH (WW),
      .DEPTH (PREFETCH_DEPTH)
   ) u_fifo (
      .clka     (clka),
      .rsta     (rsta),
      .flush    (frame_start_i),
      .push     (fifo_push),
      .push_dat (douta_i),
      .pop      (fifo_pop),
      .head_dat (fifo_head),
      .count    (fifo_count),
      .empty    (fifo_empty)
   );

   // Read FSM next state: decide next cycle's read from the occupancy it will see.
   always_comb begin
      b_run  = (rd_state == RD_RUN);
      b_word = rd_word;
      b_rep  = rd_rep;
      b_line = rd_line;
      // Words held next cycle: current count, landing word, read now in flight, minus a pop.
      occ    = OCC_W'(fifo_count) + OCC_W'(rd_pend) + OCC_W'(ena_o) - OCC_W'(fifo_pop);
      rd_state_nxt = rd_state;
      if (frame_start_i) begin
         b_run        = 1'b1;
         b_word       = '0;
         b_rep        = '0;
         b_line       = '0;
         occ          = '0;
         rd_state_nxt = RD_RUN;
      end
      rd_word_nxt = b_word;
      rd_rep_nxt  = b_rep;
      rd_line_nxt = b_line;
      ena_nxt     = 1'b0;
      addra_nxt   = addra_o;
      if (b_run && (occ < OCC_W'(PREFETCH_DEPTH))) begin
         ena_nxt   = 1'b1;
         addra_nxt = AW'(int'(b_line) * LINE_WORDS + int'(b_word));
         if (b_word == WD_W'(LINE_WORDS - 1)) begin
            rd_word_nxt = '0;
            if (b_rep == RP_W'(SCALE - 1)) begin
               rd_rep_nxt = '0;
               if (b_line == LN_W'(SRC_H - 1)) begin
                  rd_line_nxt  = '0;
                  rd_state_nxt = RD_IDLE;
               end else begin
                  rd_line_nxt = b_line + 1'b1;
               end
            end else begin
               rd_rep_nxt = b_rep + 1'b1;
            end
         end else begin
            rd_word_nxt = b_word + 1'b1;
         end
      end
   end

   // Read FSM registers; a restart drops whatever read is still returning.
   always_ff @(posedge clka) begin
      if (rsta) begin
         rd_state <= RD_IDLE;
         rd_word  <= '0;
         rd_rep   <= '0;
         rd_line  <= '0;
         ena_o    <= 1'b0;
         addra_o  <= '0;
         rd_pend  <= 1'b0;
      end else begin
         rd_state <= rd_state_nxt;
         rd_word  <= rd_word_nxt;
         rd_rep   <= rd_rep_nxt;
         rd_line  <= rd_line_nxt;
         ena_o    <= ena_nxt;
         addra_o  <= addra_nxt;
         rd_pend  <= frame_start_i ? 1'b0 : ena_o;
      end
   end

   // Output FSM next state: replicate, unpack, and track raster position for frame end.
   always_comb begin
      out_state_nxt = out_state;
      sub_nxt       = sub;
      hrep_nxt      = hrep;
      out_x_nxt     = out_x;
      out_y_nxt     = out_y;
      done_nxt      = 1'b0;
      if (frame_start_i) begin
         out_state_nxt = OUT_RUN;
         sub_nxt       = '0;
         hrep_nxt      = '0;
         out_x_nxt     = '0;
         out_y_nxt     = '0;
      end else if (xfer) begin
         if (hrep == RP_W'(SCALE - 1)) begin
            hrep_nxt = '0;
            sub_nxt  = (sub == SUB_W'(PIXELS_PER_WORD - 1)) ? '0 : sub + 1'b1;
         end else begin
            hrep_nxt = hrep + 1'b1;
         end
         if (out_x == X_W'(DISP_WIDTH - 1)) begin
            out_x_nxt = '0;
            if (out_y == Y_W'(DISP_HEIGHT - 1)) begin
               out_y_nxt     = '0;
               out_state_nxt = OUT_IDLE;
               done_nxt      = 1'b1;
            end else begin
               out_y_nxt = out_y + 1'b1;
            end
         end else begin
            out_x_nxt = out_x + 1'b1;
         end
      end
   end

   // Output FSM registers and the registered end-of-frame pulse.
   always_ff @(posedge clka) begin
      if (rsta) begin
         out_state    <= OUT_IDLE;
         sub          <= '0;
         hrep         <= '0;
         out_x        <= '0;
         out_y        <= '0;
         frame_done_o <= 1'b0;
      end else begin
         out_state    <= out_state_nxt;
         sub          <= sub_nxt;
         hrep         <= hrep_nxt;
         out_x        <= out_x_nxt;
         out_y        <= out_y_nxt;
         frame_done_o <= done_nxt;
      end
   end

`ifdef VGA_FBUF_UNDERRUN_EN
   // Sticky flag: consumer wanted a pixel while the frame was running but none was ready.
   always_ff @(posedge clka) begin
      if (rsta || frame_start_i) underrun_o <= 1'b0;
      else if ((out_state == OUT_RUN) && pix_ready_i && !pix_valid_o) underrun_o <= 1'b1;
   end
`endif

endmodule
